// File: rtl/crc_check_sched_pkg.sv
// Shared types and constants for the CRC checker scheduler.
package crc_sched_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam logic [7:0]  CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

    // Reference byte update of the engine's CRC-8, MSB first, zero init.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_check_sched_rr_arbiter.sv
// Rotating-priority arbiter: first active request at or after ptr wins.
module rr_arbiter
    import crc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_check_sched.sv
// Round-robin scheduler sharing one byte-serial CRC-8 checker between requesters.
module crc_check_sched
    import crc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned FRAME_LEN = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   res_valid,
    output logic                 res_error,
    output logic                 res_timeout,
    output logic                 crc_start,
    output logic [7:0]           crc_data,
    output logic                 crc_valid,
    input  logic                 crc_done,
    input  logic                 crc_error
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [PW-1:0]      next_ptr;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   tmo_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt)
    );

    // Index of the current one-hot grant, for the data mux and pointer advance.
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
        next_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    // Byte path is a straight pass-through of the granted lane while streaming.
    always_comb begin
        req_ready = '0;
        crc_data  = '0;
        if (state == ST_STREAM) begin
            req_ready = gnt;
            crc_data  = req_data[{gidx, 3'b000} +: 8];
        end
        crc_valid = |(req_ready & req_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            res_valid   <= '0;
            res_error   <= 1'b0;
            res_timeout <= 1'b0;
            crc_start   <= 1'b0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            crc_start <= 1'b0;
            res_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt       <= arb_gnt;
                        crc_start <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                    state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (crc_valid) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == CNT_W'(FRAME_LEN - 1)) state <= ST_WAIT;
                    end
                end
                // A done on the final timeout cycle still counts as a response.
                ST_WAIT: begin
                    if (crc_done) begin
                        res_valid   <= gnt;
                        res_error   <= crc_error;
                        res_timeout <= 1'b0;
                        state       <= ST_RESULT;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_valid   <= gnt;
                        res_error   <= 1'b1;
                        res_timeout <= 1'b1;
                        state       <= ST_RESULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESULT: begin
                    ptr         <= next_ptr;
                    gnt         <= '0;
                    res_error   <= 1'b0;
                    res_timeout <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
